// File: rtl/x_stream_tx.sv
// Ping-pong stream source: host words fill two LENX-word banks and each
// completed bank is replayed in fill order over a valid/ready master port.
module x_stream_tx #(
  parameter int WIDTH  = 8,
  parameter int LENX   = 8,
  parameter int LOGLEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  output logic [15:0]      vec_count,
  output logic             busy
);

  // Handshakes: a word moves on a rising edge where valid && ready. Once a
  // master raises valid it holds valid and data stable until that edge.

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;

  localparam int LAST_I = LENX - 1;
  localparam logic [LOGLEN-1:0] LAST_IDX = LAST_I[LOGLEN-1:0];
  localparam logic [LOGLEN:0]   END_RI   = LENX[LOGLEN:0];

  logic [WIDTH-1:0] bank [2][LENX];
  logic [1:0]        full;
  logic              fb;
  logic              tb;
  logic [LOGLEN-1:0] wi;
  logic [LOGLEN:0]   ri;
  logic              state;

  logic             wr_hs;
  logic             wr_last;
  logic             tx_hs;
  logic             tx_last;
  logic             other_ready;
  logic [WIDTH-1:0] other_word0;

  assign wr_ready = !reset && !full[fb];
  assign wr_hs    = wr_valid && wr_ready;
  assign wr_last  = wr_hs && (wi == LAST_IDX);
  assign tx_hs    = (state == S_SEND) && m_valid_x && m_ready_x;
  assign tx_last  = tx_hs && (ri == END_RI);
  assign busy     = full[0] || full[1] || (state == S_SEND);

  // The other bank counts as ready if it completes on this very edge, so a
  // fill finishing together with a transmit still chains without a bubble.
  assign other_ready = full[~tb] || (wr_last && (fb == ~tb));
  assign other_word0 = (wr_hs && (fb == ~tb) && (wi == '0)) ? wr_data : bank[~tb][0];

  always_ff @(posedge clk) begin
    if (wr_hs) begin
      bank[fb][wi] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full         <= '0;
      fb           <= 1'b0;
      wi           <= '0;
      tb           <= 1'b0;
      ri           <= '0;
      state        <= S_IDLE;
      m_data_out_x <= '0;
      m_valid_x    <= 1'b0;
      vec_count    <= '0;
    end else begin
      if (wr_hs) begin
        if (wi == LAST_IDX) begin
          full[fb] <= 1'b1;
          wi       <= '0;
          fb       <= ~fb;
        end else begin
          wi <= wi + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (full[tb]) begin
            m_data_out_x <= bank[tb][0];
            ri           <= 1;
            m_valid_x    <= 1'b1;
            state        <= S_SEND;
          end
        end
        default: begin
          if (tx_hs) begin
            if (!tx_last) begin
              m_data_out_x <= bank[tb][ri[LOGLEN-1:0]];
              ri           <= ri + 1'b1;
            end else begin
              full[tb]  <= 1'b0;
              tb        <= ~tb;
              vec_count <= vec_count + 1'b1;
              if (other_ready) begin
                m_data_out_x <= other_word0;
                ri           <= 1;
              end else begin
                m_valid_x <= 1'b0;
                ri        <= '0;
                state     <= S_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_stream_tx.sv
// Directed bench for x_stream_tx: linear steps, immediate assertions, and an
// expected-word queue drained by a negedge monitor.
module tb_x_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  m_data_out_x;
  logic        m_valid_x;
  logic        m_ready_x;
  logic [15:0] vec_count;
  logic        busy;

  logic ready_drv = 1'b0;
  logic rnd_mode  = 1'b0;
  logic rnd_bit   = 1'b0;
  assign m_ready_x = rnd_mode ? rnd_bit : ready_drv;

  int         tests = 0;
  int         fails = 0;
  int         hs_count = 0;
  int         drop_cnt = 0;
  int         stall_cnt = 0;
  bit         sim_done = 1'b0;
  logic [7:0] exp_q[$];

  x_stream_tx #(.WIDTH(8), .LENX(8), .LOGLEN(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .vec_count    (vec_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor_loop();
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data  = '0;
    logic [7:0] exp;
    while (!sim_done) begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid_x), 1);
          check("hold_data", 32'(m_data_out_x), 32'(prev_data));
        end
        if (m_valid_x && m_ready_x) begin
          tests++;
          assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL extra_word: observed %0h expected no word", m_data_out_x);
          end
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("stream_data", 32'(m_data_out_x), 32'(exp));
          end
          hs_count++;
        end
        if (prev_valid && !m_valid_x) drop_cnt++;
        prev_stall = m_valid_x && !m_ready_x;
        prev_data  = m_data_out_x;
        prev_valid = m_valid_x;
      end
    end
  endtask

  task automatic rnd_loop();
    while (!sim_done) begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    int n = 0;
    bit hs = 1'b0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = wr_ready;
      @(posedge clk);
      #1;
      n++;
      if (!hs) stall_cnt++;
    end
    check("wr_accept", 32'(hs), 1);
    if (hs) exp_q.push_back(d);
  endtask

  task automatic wait_vec(input int n);
    int k = 0;
    while (vec_count != 16'(n) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("vec_count", 32'(vec_count), n);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    ready_drv = 1'b0;
    rnd_mode  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_valid", 32'(m_valid_x), 0);
    check("rst_data", 32'(m_data_out_x), 0);
    check("rst_vec_count", 32'(vec_count), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    #1;
    check("rel_wr_ready", 32'(wr_ready), 1);
  endtask

  task automatic stimulus();
    logic [7:0] v1 [8] = '{8'd10, 8'd7, 8'd3, 8'd4, 8'hFF, 8'h00, 8'h7F, 8'h80};
    int h0;
    int d0;

    // Single vector, always ready
    do_reset();
    ready_drv = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 8; i++) write_word(v1[i]);
    wr_valid = 1'b0;
    check("t1_valid_latency", 32'(m_valid_x), 0);
    check("t1_busy_full", 32'(busy), 1);
    @(posedge clk); #1;
    check("t1_valid_rise", 32'(m_valid_x), 1);
    check("t1_word0", 32'(m_data_out_x), 10);
    wait_vec(1);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_valid_low", 32'(m_valid_x), 0);
    check("t1_last_hold", 32'(m_data_out_x), 32'h80);
    check("t1_hs", 32'(hs_count - h0), 8);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // Back-to-back, three vectors
    do_reset();
    ready_drv = 1'b1;
    stall_cnt = 0;
    d0 = drop_cnt;
    for (int i = 0; i < 24; i++) write_word(8'(i * 7 + 1));
    wr_valid = 1'b0;
    check("t2_stalls", 32'(stall_cnt), 1);
    wait_vec(3);
    check("t2_no_gap", 32'(drop_cnt - d0), 0);
    check("t2_valid_end", 32'(m_valid_x), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // Random backpressure, 100 vectors
    do_reset();
    rnd_mode = 1'b1;
    h0 = hs_count;
    for (int v = 0; v < 100; v++) begin
      for (int w = 0; w < 8; w++) begin
        if ($urandom_range(0, 2) == 0) begin
          wr_valid = 1'b0;
          @(posedge clk); #1;
        end
        write_word(8'($urandom));
      end
    end
    wr_valid = 1'b0;
    wait_vec(100);
    check("t3_hs", 32'(hs_count - h0), 800);
    check("t3_q_empty", 32'(exp_q.size()), 0);
    rnd_mode = 1'b0;

    // Full stall with both banks loaded
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(8'h20 + i));
    check("t4_full_stall", 32'(wr_ready), 0);
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_no_accept", 32'(wr_ready), 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("t4_valid_held", 32'(m_valid_x), 1);
    check("t4_word0_held", 32'(m_data_out_x), 32'h20);
    ready_drv = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t4_still_full", 32'(wr_ready), 0);
    @(posedge clk); #1;
    check("t4_release", 32'(wr_ready), 1);
    check("t4_vec1", 32'(vec_count), 1);
    check("t4_bank1_word0", 32'(m_data_out_x), 32'h28);
    wait_vec(2);
    check("t4_q_empty", 32'(exp_q.size()), 0);

    // Partial fill does not transmit
    do_reset();
    ready_drv = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 5; i++) write_word(8'(8'h40 + i));
    wr_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t5_valid_off", 32'(m_valid_x), 0);
    check("t5_busy_off", 32'(busy), 0);
    check("t5_no_hs", 32'(hs_count - h0), 0);
    for (int i = 5; i < 8; i++) write_word(8'(8'h40 + i));
    wr_valid = 1'b0;
    wait_vec(1);
    check("t5_hs", 32'(hs_count - h0), 8);
    check("t5_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset during the 4th word of the second vector
    do_reset();
    ready_drv = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'(8'h31 + i));
    for (int i = 0; i < 8; i++) write_word(8'(8'h11 + i));
    wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_word3", 32'(m_data_out_x), 32'h14);
    check("t6_vec_before", 32'(vec_count), 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_valid_abort", 32'(m_valid_x), 0);
    check("t6_vec_clear", 32'(vec_count), 0);
    check("t6_wr_ready_rst", 32'(wr_ready), 0);
    check("t6_busy_clear", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    h0 = hs_count;
    for (int i = 1; i <= 8; i++) write_word(8'(i));
    wr_valid = 1'b0;
    wait_vec(1);
    check("t6_hs", 32'(hs_count - h0), 8);
    check("t6_last_word", 32'(m_data_out_x), 8);
    check("t6_q_empty", 32'(exp_q.size()), 0);

    sim_done = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    fork
      monitor_loop();
      rnd_loop();
      stimulus();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/x_stream_tx.md
# x_stream_tx

Transmit-side stream source for the convolution engines' x input. It collects words from a host write port into two ping-pong vector banks of LENX words each and replays each completed vector, in order, over the valid/ready master interface that drives an engine's s_data_in_x / s_valid_x / s_ready_x port. It sits between the host/DMA side and any conv_* block. While one bank is being transmitted, the other can be filled.

## Interface
Parameters:
- WIDTH, 8, word width in bits.
- LENX, 8, words per vector (per bank).
- LOGLEN, 3, index width; must satisfy 2**LOGLEN >= LENX.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
- wr_data  input  WIDTH  host word to store.
- wr_valid  input  1  host offers wr_data.
- wr_ready  output  1  block can accept a host word.
- m_data_out_x  output  WIDTH  word presented to the engine (signed two's complement; passed through unmodified).
- m_valid_x  output  1  m_data_out_x is valid.
- m_ready_x  input  1  engine accepts the word (the engine's s_ready_x).
- vec_count  output  16  vectors fully transmitted since reset; wraps 0xFFFF->0.
- busy  output  1  any bank is full, or a transmit is in progress.

## Operation
- Storage: two banks of LENX x WIDTH registers, with asynchronous read mux. Each bank has a full flag.
- Fill side:
  - The fill pointer fb (0/1) selects the bank being written; the write index is wi.
  - wr_ready = !reset && !full[fb].
  - A write handshake (wr_valid && wr_ready) stores wr_data at bank[fb][wi], then increments wi.
  - On the handshake with wi == LENX-1: full[fb] <= 1, wi <= 0, fb <= ~fb.
- Transmit FSM (states IDLE, SEND; transmit pointer tb, read index ri):
  - IDLE: if full[tb], load m_data_out_x <= bank[tb][0], set ri <= 1, m_valid_x <= 1, and go to SEND.
  - SEND, handshake (m_valid_x && m_ready_x) with ri-1 < LENX-1: load m_data_out_x <= bank[tb][ri], ri <= ri+1. m_valid_x stays 1, so there are no bubbles.
  - SEND, handshake on the last word: full[tb] <= 0, tb <= ~tb, vec_count <= vec_count+1.
    - If full[~tb] in that same cycle: load word 0 of the other bank, ri <= 1, and stay in SEND. The next vector follows back-to-back.
    - Otherwise: m_valid_x <= 0, m_data_out_x holds its last value, and the FSM goes to IDLE.
  - SEND without a handshake: m_data_out_x and m_valid_x stay stable. Once m_valid_x is high, it never drops before the handshake.
- Ordering: vectors leave in the order they were filled. Words within a vector leave in index order 0..LENX-1.
- busy = full[0] || full[1] || (state == SEND).

## Timing
- Reset values: wr_ready=0 while reset is asserted (1 after release with empty banks), m_valid_x=0, m_data_out_x=0, vec_count=0, busy=0, fb=tb=0, wi=ri=0, state=IDLE, both full flags 0.
- Fill-to-transmit latency: the last write handshake completes at edge E; m_valid_x rises after edge E+1 with word 0.
- Throughput: one word per cycle on both sides when wr_valid and m_ready_x are held high. A continuous stream sustains LENX words per LENX cycles with no gap between vectors.
- Both banks full: wr_ready=0 until the transmit releases a bank. The release edge clears full, so wr_ready returns to 1 in the next cycle.
- Simultaneous events in one cycle:
  - A last-word write into bank B and a last-word transmit of bank A are both legal and both take effect.
  - A write into bank B while bank B is being released cannot occur, since fill never targets a full bank.
- Reset mid-operation: asynchronous abort. Partial vectors and pending banks are discarded, m_valid_x drops immediately, and vec_count clears.

## Test plan
- Single vector, always-ready: after reset, write 10,7,3,4,-1,0,127,-128 (LENX=8) with wr_valid held 1 and m_ready_x held 1.
  - m_valid_x rises 1 cycle after the 8th write edge, then the same 8 values appear on 8 consecutive cycles.
  - vec_count=1, then busy=0.
- Back-to-back: write 3 vectors continuously, m_ready_x=1.
  - wr_ready drops only when both banks are full.
  - Output is 24 words with m_valid_x never low between vectors.
  - vec_count=3.
- Backpressure: m_ready_x driven by a random bit each cycle while writing 100 random vectors with random wr_valid.
  - Output sequence exactly equals the input sequence.
  - m_data_out_x is stable whenever m_valid_x=1 && m_ready_x=0.
  - vec_count=100.
- Full stall: m_ready_x=0, write 16 words.
  - wr_ready=0 after the 16th write; a 17th offered word is not accepted.
  - Raising m_ready_x for 8 handshakes releases bank 0, and wr_ready=1 in the next cycle.
- Partial fill: write 5 words and stop. m_valid_x stays 0 indefinitely and busy=0.
  - Completing with 3 more words starts transmission of all 8 in order.
- Reset mid-send: assert reset asynchronously (between clock edges) during the 4th word of a transmit.
  - m_valid_x=0 and vec_count=0 immediately.
  - After release, a new vector 1..8 transmits correctly, with no stale words.
